// File: rtl/radix4_pkg.sv
// Strobe bit indices and Booth digit decoding shared by the radix-4 controller and datapath.
package radix4_pkg;

    localparam int unsigned LD_M    = 0;
    localparam int unsigned LD_Q    = 1;
    localparam int unsigned LD_A    = 2;
    localparam int unsigned LD_SH   = 3;
    localparam int unsigned LD_CNT  = 4;

    localparam int unsigned SEL_ACC = 0;
    localparam int unsigned SEL_CNT = 1;
    localparam int unsigned SEL_ZPP = 2;
    localparam int unsigned SEL_PRD = 3;

    typedef enum logic [2:0] {
        PpZero,
        PpPosM,
        PpPos2M,
        PpNegM,
        PpNeg2M
    } pp_sel_e;

    // Digit is {Q[1], Q[0], q_m1}.
    function automatic pp_sel_e booth_decode(input logic [2:0] digit);
        case (digit)
            3'b000, 3'b111: return PpZero;
            3'b001, 3'b010: return PpPosM;
            3'b011:         return PpPos2M;
            3'b100:         return PpNeg2M;
            default:        return PpNegM;
        endcase
    endfunction

endpackage

// File: rtl/radix4_datapath_if.sv
// Controller <-> datapath bundle; debug taps exist only when RADIX4_DBG_EN is defined.
interface radix4_datapath_if #(
    parameter int unsigned WIDTH = 8
);
    logic [4:0]         ld;
    logic [4:0]         sel;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic               flag;
    logic [2*WIDTH-1:0] product;
`ifdef RADIX4_DBG_EN
    logic [2:0]         dbg_digit;
    logic [WIDTH+1:0]   dbg_pp;

    modport master (output ld, sel, a_in, b_in, input flag, product, dbg_digit, dbg_pp);
    modport slave  (input ld, sel, a_in, b_in, output flag, product, dbg_digit, dbg_pp);
`else
    modport master (output ld, sel, a_in, b_in, input flag, product);
    modport slave  (input ld, sel, a_in, b_in, output flag, product);
`endif
endinterface

// File: rtl/radix4_booth_enc.sv
// Radix-4 Booth encoder: maps a digit to a partial product of 0, +M, +2M, -M or -2M.
module radix4_booth_enc
    import radix4_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2:0]       digit,
    input  logic             zero,
    input  logic [WIDTH+1:0] m,
    output logic [WIDTH+1:0] pp
);
    localparam logic [WIDTH+1:0] One = 1;

    logic [WIDTH+1:0] m2;

    assign m2 = {m[WIDTH:0], 1'b0};

    always_comb begin
        pp = '0;
        unique case (booth_decode(digit))
            PpZero:  pp = '0;
            PpPosM:  pp = m;
            PpPos2M: pp = m2;
            PpNegM:  pp = ~m + One;
            PpNeg2M: pp = ~m2 + One;
            default: pp = '0;
        endcase
        if (zero) begin
            pp = '0;
        end
    end

endmodule

// File: rtl/radix4_datapath.sv
// Radix-4 Booth multiplier datapath driven by controller ld/sel strobes.
// Optional debug taps (dbg_digit, dbg_pp) are enabled by defining RADIX4_DBG_EN.
module radix4_datapath
    import radix4_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    radix4_datapath_if.slave bus
);
    localparam int unsigned      CNT_W   = $clog2(WIDTH / 2) + 1;
    localparam logic [CNT_W-1:0] CntInit = CNT_W'(WIDTH / 2);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic [WIDTH+1:0]   m_q, m_d, a_q, a_d, a_add, pp;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flag_q, flag_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [2:0]         digit;

    assign digit = {q_q[1:0], qm1_q};

    radix4_booth_enc #(
        .WIDTH(WIDTH)
    ) u_booth_enc (
        .digit(digit),
        .zero (bus.sel[SEL_ZPP]),
        .m    (m_q),
        .pp   (pp)
    );

    always_comb begin
        m_d       = m_q;
        a_add     = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        flag_d    = flag_q;
        product_d = product_q;

        if (bus.ld[LD_M]) begin
            m_d = {{2{bus.a_in[WIDTH-1]}}, bus.a_in};
        end
        if (bus.ld[LD_A]) begin
            a_add = bus.sel[SEL_ACC] ? a_q + pp : '0;
        end
        a_d = a_add;
        // Shift sees the freshly added accumulator so add+shift can share a cycle.
        if (bus.ld[LD_SH]) begin
            a_d   = {{2{a_add[WIDTH+1]}}, a_add[WIDTH+1:2]};
            q_d   = {a_add[1:0], q_q[WIDTH-1:2]};
            qm1_d = q_q[1];
        end
        if (bus.ld[LD_Q]) begin
            q_d   = bus.b_in;
            qm1_d = 1'b0;
        end
        if (bus.ld[LD_CNT]) begin
            if (!bus.sel[SEL_CNT]) begin
                cnt_d  = CntInit;
                flag_d = 1'b0;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    flag_d = 1'b1;
                end
            end
        end
        if (bus.sel[SEL_PRD]) begin
            product_d = {a_q[WIDTH-1:0], q_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            flag_q    <= 1'b0;
            product_q <= '0;
        end else begin
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            flag_q    <= flag_d;
            product_q <= product_d;
        end
    end

    assign bus.flag    = flag_q;
    assign bus.product = product_q;

`ifdef RADIX4_DBG_EN
    assign bus.dbg_digit = digit;
    assign bus.dbg_pp    = pp;
`endif

endmodule

// File: tb/tb_radix4_datapath.sv
// Self-checking bench for radix4_datapath: vector table, corner sequences, random add/shift modes.
module tb_radix4_datapath;

    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [15:0] exp_q[$];
    vec_t vecs[7];

    radix4_datapath_if #(.WIDTH(WIDTH)) bus ();

    radix4_datapath #(
        .WIDTH(WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [4:0] l, input logic [4:0] s);
        bus.ld  = l;
        bus.sel = s;
        @(posedge clk);
        #1;
        bus.ld  = '0;
        bus.sel = '0;
    endtask

    // Load M, Q, clear A, load counter.
    task automatic load(input logic [7:0] a, input logic [7:0] b);
        bus.a_in = a;
        bus.b_in = b;
        cyc(5'b10111, 5'b00000);
    endtask

    task automatic iter(input bit split);
        if (split) begin
            cyc(5'b00100, 5'b00001);
            cyc(5'b11000, 5'b00010);
        end else begin
            cyc(5'b11100, 5'b00011);
        end
    endtask

    task automatic latch();
        cyc(5'b00000, 5'b01000);
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    // Full controller-style multiply; expected value must already be queued.
    task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input bit split,
                            input string name);
        logic [15:0] exp;
        load(a, b);
        for (int k = 0; k < 4; k++) iter(split);
        latch();
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got %h, expected a queued value", name,
                     bus.product);
        end else begin
            exp = exp_q.pop_front();
            check(name, bus.product, exp);
        end
        check({name, "_flag"}, 16'(bus.flag), 16'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{a: 8'd5,   b: 8'd3,   exp: 16'h000F};
        vecs[1] = '{a: 8'hF8,  b: 8'd7,   exp: 16'hFFC8};
        vecs[2] = '{a: 8'h80,  b: 8'h80,  exp: 16'h4000};
        vecs[3] = '{a: 8'h00,  b: 8'h55,  exp: 16'h0000};
        vecs[4] = '{a: 8'h7F,  b: 8'h00,  exp: 16'h0000};
        vecs[5] = '{a: 8'h7F,  b: 8'h80,  exp: 16'hC080};
        vecs[6] = '{a: 8'hFF,  b: 8'hFF,  exp: 16'h0001};

        rst      = 1'b1;
        bus.ld   = '0;
        bus.sel  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_product", bus.product, 16'h0000);
        check("reset_flag", 16'(bus.flag), 16'd0);

        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(vecs[i].exp);
            run_mult(vecs[i].a, vecs[i].b, 1'b0, $sformatf("vec%0d", i));
        end

        // Flag must rise on exactly the fourth decrement after a counter load.
        load(8'h00, 8'h55);
        check("cnt_load_flag", 16'(bus.flag), 16'd0);
        for (int k = 1; k <= 4; k++) begin
            iter(1'b0);
            check($sformatf("flag_after_dec%0d", k), 16'(bus.flag), (k == 4) ? 16'd1 : 16'd0);
        end
        cyc(5'b10000, 5'b00010);
        check("flag_saturated", 16'(bus.flag), 16'd1);
        cyc(5'b10000, 5'b00000);
        check("flag_reload", 16'(bus.flag), 16'd0);
        for (int k = 1; k <= 4; k++) begin
            cyc(5'b10000, 5'b00010);
            check($sformatf("reload_dec%0d", k), 16'(bus.flag), (k == 4) ? 16'd1 : 16'd0);
        end

        // Reset mid-operation overrides every strobe.
        exp_q.push_back(16'h000F);
        run_mult(8'd5, 8'd3, 1'b0, "pre_rst");
        load(8'd5, 8'd3);
        iter(1'b0);
        iter(1'b0);
        rst = 1'b1;
        cyc(5'b11111, 5'b11111);
        rst = 1'b0;
        check("midrst_product", bus.product, 16'h0000);
        check("midrst_flag", 16'(bus.flag), 16'd0);
        latch();
        check("midrst_aq_clear", bus.product, 16'h0000);
        exp_q.push_back(16'h000F);
        run_mult(8'd5, 8'd3, 1'b0, "post_rst");

        // Product latch in the same cycle as a shift captures the pre-shift state.
        load(8'd5, 8'd3);
        for (int k = 0; k < 3; k++) iter(1'b0);
        cyc(5'b11100, 5'b01011);
        check("latch_preshift", bus.product, 16'h003C);
        check("latch_preshift_flag", 16'(bus.flag), 16'd1);
        latch();
        check("latch_final", bus.product, 16'h000F);
        repeat (3) cyc(5'b00000, 5'b00000);
        check("idle_hold", bus.product, 16'h000F);

        // Combined and split add/shift must both match the signed product.
        for (int i = 0; i < 100; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            exp_q.push_back(model(ra, rb));
            run_mult(ra, rb, 1'b0, $sformatf("rnd%0d_comb", i));
            exp_q.push_back(model(ra, rb));
            run_mult(ra, rb, 1'b1, $sformatf("rnd%0d_split", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
